// File: rtl/stack_cpu_exec_unit.sv
// Decode, ALU and data RAM for the single-cycle stack CPU.
// Takes the instruction, PC and top two stack entries; returns the stack strobes, the push value and the next PC.
module stack_cpu_exec_unit #(
    parameter int DBITS  = 32,
    parameter int MEM_AW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst,
    input  logic [31:0]      pc,
    input  logic [DBITS-1:0] tos,
    input  logic [DBITS-1:0] nos,
    output logic             read_reg1,
    output logic             read_reg2,
    output logic             write_reg,
    output logic [3:0]       alu_ctl,
    output logic             branch,
    output logic [DBITS-1:0] alu_result,
    output logic [DBITS-1:0] mem_rdata,
    output logic [DBITS-1:0] reg_wdata,
    output logic [31:0]      next_pc
);

    localparam logic [3:0] CTL_ADD   = 4'h0;
    localparam logic [3:0] CTL_SUB   = 4'h1;
    localparam logic [3:0] CTL_AND   = 4'h2;
    localparam logic [3:0] CTL_OR    = 4'h3;
    localparam logic [3:0] CTL_XOR   = 4'h4;
    localparam logic [3:0] CTL_SHL   = 4'h5;
    localparam logic [3:0] CTL_SHR   = 4'h6;
    localparam logic [3:0] CTL_SLT   = 4'h7;
    localparam logic [3:0] CTL_PASSB = 4'h8;
    localparam logic [3:0] CTL_BEQZ  = 4'h9;
    localparam logic [3:0] CTL_BNEZ  = 4'hA;

    logic [5:0]       opcode;
    logic [DBITS-1:0] imm;
    logic             read_mem;
    logic             write_mem;
    logic             mem_to_reg;
    logic             pc_to_reg;
    logic             reg_to_pc;
    logic             alu_src;
    logic [DBITS-1:0] operand1;
    logic [DBITS-1:0] operand2;
    logic [MEM_AW-1:0] mem_addr;
    logic [DBITS-1:0] mem_q [2**MEM_AW];

    assign opcode = inst[31:26];
    // inst[25] is the sign bit; it also fills bit 9 above the 9-bit magnitude field.
    assign imm    = {{(DBITS-9){inst[25]}}, inst[24:16]};

    always_comb begin
        read_reg1  = 1'b0;
        read_reg2  = 1'b0;
        write_reg  = 1'b0;
        read_mem   = 1'b0;
        write_mem  = 1'b0;
        mem_to_reg = 1'b0;
        pc_to_reg  = 1'b0;
        reg_to_pc  = 1'b0;
        alu_src    = 1'b0;
        alu_ctl    = CTL_ADD;
        case (opcode)
            6'h01: begin
                write_reg = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = CTL_PASSB;
            end
            6'h02: read_reg1 = 1'b1;
            6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A: begin
                read_reg1 = 1'b1;
                read_reg2 = 1'b1;
                write_reg = 1'b1;
                alu_ctl   = 4'(opcode - 6'h03);
            end
            6'h0B: begin
                read_reg1 = 1'b1;
                write_reg = 1'b1;
                alu_src   = 1'b1;
                alu_ctl   = CTL_ADD;
            end
            6'h0C: begin
                read_reg1  = 1'b1;
                read_mem   = 1'b1;
                mem_to_reg = 1'b1;
                write_reg  = 1'b1;
            end
            6'h0D: begin
                read_reg1 = 1'b1;
                read_reg2 = 1'b1;
                write_mem = 1'b1;
            end
            6'h0E: begin
                read_reg1 = 1'b1;
                reg_to_pc = 1'b1;
            end
            6'h0F: begin
                read_reg1 = 1'b1;
                reg_to_pc = 1'b1;
                pc_to_reg = 1'b1;
                write_reg = 1'b1;
            end
            6'h10: begin
                read_reg1 = 1'b1;
                read_reg2 = 1'b1;
                alu_ctl   = CTL_BEQZ;
            end
            6'h11: begin
                read_reg1 = 1'b1;
                read_reg2 = 1'b1;
                alu_ctl   = CTL_BNEZ;
            end
            default: ;
        endcase
    end

    assign operand1 = tos;
    assign operand2 = alu_src ? imm : nos;

    always_comb begin
        alu_result = '0;
        branch     = 1'b0;
        case (alu_ctl)
            CTL_ADD:   alu_result = operand1 + operand2;
            CTL_SUB:   alu_result = operand1 - operand2;
            CTL_AND:   alu_result = operand1 & operand2;
            CTL_OR:    alu_result = operand1 | operand2;
            CTL_XOR:   alu_result = operand1 ^ operand2;
            CTL_SHL:   alu_result = operand1 << operand2[4:0];
            CTL_SHR:   alu_result = operand1 >> operand2[4:0];
            CTL_SLT:   alu_result = ($signed(operand1) < $signed(operand2)) ? DBITS'(1) : '0;
            CTL_PASSB: alu_result = operand2;
            CTL_BEQZ:  branch = (operand2 == '0);
            CTL_BNEZ:  branch = (operand2 != '0);
            default:   ;
        endcase
    end

    // Only the low MEM_AW bits of TOS address the RAM, so addresses wrap.
    assign mem_addr = tos[MEM_AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**MEM_AW; i++) begin
                mem_q[i] <= '0;
            end
        end else if (write_mem) begin
            mem_q[mem_addr] <= nos;
        end
    end

    assign mem_rdata = (read_mem && !reset) ? mem_q[mem_addr] : '0;

    always_comb begin
        if (pc_to_reg) begin
            reg_wdata = DBITS'(pc + 32'd2);
        end else if (mem_to_reg) begin
            reg_wdata = mem_rdata;
        end else begin
            reg_wdata = alu_result;
        end
    end

    assign next_pc = (reg_to_pc || branch) ? 32'(tos) : pc + 32'd1;

    logic unused_bits;
    assign unused_bits = ^{inst[15:0], tos[DBITS-1:MEM_AW]};

endmodule

// File: tb/tb_stack_cpu_exec_unit.sv
// Directed bench for stack_cpu_exec_unit with hand-computed expected values.
module tb_stack_cpu_exec_unit;

    logic        clk;
    logic        reset;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] tos;
    logic [31:0] nos;
    logic        read_reg1;
    logic        read_reg2;
    logic        write_reg;
    logic [3:0]  alu_ctl;
    logic        branch;
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [31:0] reg_wdata;
    logic [31:0] next_pc;

    int err_cnt = 0;
    int chk_cnt = 0;

    stack_cpu_exec_unit #(.DBITS(32), .MEM_AW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst       (inst),
        .pc         (pc),
        .tos        (tos),
        .nos        (nos),
        .read_reg1  (read_reg1),
        .read_reg2  (read_reg2),
        .write_reg  (write_reg),
        .alu_ctl    (alu_ctl),
        .branch     (branch),
        .alu_result (alu_result),
        .mem_rdata  (mem_rdata),
        .reg_wdata  (reg_wdata),
        .next_pc    (next_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [9:0] imm10);
        return {op, imm10, 16'h0000};
    endfunction

    // Apply one instruction and let combinational outputs settle.
    task automatic drive(input logic [5:0] op, input logic [9:0] imm10,
                         input logic [31:0] p, input logic [31:0] t, input logic [31:0] n);
        inst = mk(op, imm10);
        pc   = p;
        tos  = t;
        nos  = n;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        inst  = 32'h0;
        pc    = 32'h0;
        tos   = 32'h0;
        nos   = 32'h0;

        // STORE pending across clock edges while reset is held.
        drive(6'h0D, 10'h0, 32'h0, 32'h10, 32'h12345678);
        repeat (3) @(posedge clk);
        #2;
        drive(6'h0C, 10'h0, 32'h0, 32'h10, 32'h0);
        check_eq("load_during_reset", mem_rdata, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(6'h0C, 10'h0, 32'h0, 32'h10, 32'h0);
        check_eq("reset_load_0x10", mem_rdata, 32'h0);
        drive(6'h0C, 10'h0, 32'h0, 32'h05, 32'h0);
        check_eq("reset_load_0x05", reg_wdata, 32'h0);

        // ADD
        drive(6'h03, 10'h0, 32'h100, 32'd7, 32'd5);
        check_eq("add_result", alu_result, 32'd12);
        check_eq("add_strobes", {29'h0, read_reg1, read_reg2, write_reg}, 32'h7);
        check_eq("add_next_pc", next_pc, 32'h101);
        check_eq("add_wdata", reg_wdata, 32'd12);

        drive(6'h04, 10'h0, 32'h100, 32'h0, 32'h1);
        check_eq("sub_wrap", alu_result, 32'hFFFFFFFF);
        drive(6'h0A, 10'h0, 32'h100, 32'hFFFFFFFF, 32'h1);
        check_eq("slt_signed", alu_result, 32'h1);
        drive(6'h08, 10'h0, 32'h100, 32'h8000_0001, 32'd4);
        check_eq("shl", alu_result, 32'h0000_0010);
        drive(6'h09, 10'h0, 32'h100, 32'h8000_0000, 32'd31);
        check_eq("shr_logical", alu_result, 32'h1);
        drive(6'h07, 10'h0, 32'h100, 32'hF0F0_00FF, 32'h0FF0_0F0F);
        check_eq("xor", alu_result, 32'hFF00_0FF0);

        // Immediates
        drive(6'h01, 10'h3FF, 32'h100, 32'h0, 32'h55);
        check_eq("pushi_neg", reg_wdata, 32'hFFFFFFFF);
        check_eq("pushi_ctl", {28'h0, alu_ctl}, 32'h8);
        check_eq("pushi_strobes", {29'h0, read_reg1, read_reg2, write_reg}, 32'h1);
        drive(6'h0B, 10'h003, 32'h100, 32'd10, 32'h99);
        check_eq("addi", reg_wdata, 32'd13);
        drive(6'h0B, 10'h200, 32'h100, 32'd1000, 32'h0);
        check_eq("addi_sign_only", alu_result, 32'd1000 - 32'd512);

        // STORE then LOAD, including address wrap
        @(negedge clk);
        drive(6'h0D, 10'h0, 32'h100, 32'h10, 32'hDEADBEEF);
        check_eq("store_no_push", {31'h0, write_reg}, 32'h0);
        @(posedge clk);
        #1;
        drive(6'h0C, 10'h0, 32'h101, 32'h10, 32'h0);
        check_eq("load_rdata", mem_rdata, 32'hDEADBEEF);
        check_eq("load_wdata", reg_wdata, 32'hDEADBEEF);
        drive(6'h0C, 10'h0, 32'h101, 32'h110, 32'h0);
        check_eq("load_wrap", mem_rdata, 32'hDEADBEEF);
        drive(6'h0C, 10'h0, 32'h101, 32'h11, 32'h0);
        check_eq("load_other", mem_rdata, 32'h0);
        drive(6'h03, 10'h0, 32'h101, 32'h10, 32'h0);
        check_eq("rdata_gated", mem_rdata, 32'h0);

        // Branches
        drive(6'h10, 10'h0, 32'h100, 32'h40, 32'h0);
        check_eq("beqz_taken", {31'h0, branch}, 32'h1);
        check_eq("beqz_taken_pc", next_pc, 32'h40);
        drive(6'h10, 10'h0, 32'h100, 32'h40, 32'h3);
        check_eq("beqz_not", {31'h0, branch}, 32'h0);
        check_eq("beqz_not_pc", next_pc, 32'h101);
        drive(6'h11, 10'h0, 32'h100, 32'h40, 32'h0);
        check_eq("bnez_not", {31'h0, branch}, 32'h0);
        check_eq("bnez_not_pc", next_pc, 32'h101);
        drive(6'h11, 10'h0, 32'h100, 32'h40, 32'h3);
        check_eq("bnez_taken", {31'h0, branch}, 32'h1);
        check_eq("bnez_taken_pc", next_pc, 32'h40);
        check_eq("bnez_no_push", {29'h0, read_reg1, read_reg2, write_reg}, 32'h6);

        // Jumps, wrap and undefined opcode
        drive(6'h0F, 10'h0, 32'h20, 32'h80, 32'h0);
        check_eq("call_wdata", reg_wdata, 32'h22);
        check_eq("call_wreg", {31'h0, write_reg}, 32'h1);
        check_eq("call_pc", next_pc, 32'h80);
        drive(6'h0E, 10'h0, 32'h20, 32'h1234, 32'h0);
        check_eq("jmp_pc", next_pc, 32'h1234);
        drive(6'h00, 10'h0, 32'hFFFFFFFF, 32'h77, 32'h0);
        check_eq("nop_pc_wrap", next_pc, 32'h0);
        drive(6'h3F, 10'h3FF, 32'h200, 32'h40, 32'h0);
        check_eq("undef_strobes", {29'h0, read_reg1, read_reg2, write_reg}, 32'h0);
        check_eq("undef_ctl", {28'h0, alu_ctl}, 32'h0);
        check_eq("undef_branch", {31'h0, branch}, 32'h0);
        check_eq("undef_pc", next_pc, 32'h201);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/stack_cpu_exec_unit.md
Name: stack_cpu_exec_unit

Overview:
Combined decode, execute and data-memory block of the single-cycle stack CPU. It takes the fetched instruction, the current PC and the top two stack entries (TOS, NOS). It produces stack-control strobes, the value to push, the next PC and the branch flag. It contains the opcode decoder, the 32-bit ALU and a word-addressed data RAM. The PC register, instruction memory and stack register file live outside this block.

Parameters:
DBITS, 32, data word width
MEM_AW, 8, data RAM index width (2^MEM_AW words)

Ports:
clk  in  1  clock; RAM writes on rising edge
reset  in  1  asynchronous, active-high; clears RAM
inst  in  32  current instruction
pc  in  32  current PC
tos  in  DBITS  stack top (ALU operand1, memory address, jump target)
nos  in  DBITS  second stack entry (ALU operand2 when alu_src=0, store data, branch condition)
read_reg1  out  1  pop TOS
read_reg2  out  1  pop NOS
write_reg  out  1  push reg_wdata
alu_ctl  out  4  decoded ALU operation
branch  out  1  conditional branch taken
alu_result  out  DBITS  ALU output
mem_rdata  out  DBITS  RAM read data
reg_wdata  out  DBITS  value to push
next_pc  out  32  PC for next cycle

Behaviour:
- Field extraction:
  - opcode = inst[31:26].
  - imm = sign-extend(inst[25], inst[24:16]): bits 31..10 = inst[25], bits 8..0 = inst[24:16], bit 9 = inst[25].
- Internal controls: read_mem, write_mem, mem_to_reg, pc_to_reg, reg_to_pc, alu_src. All are combinational from opcode and default to 0.
- Opcode map (any control not listed is 0):
  - 0x00 NOP: no controls.
  - 0x01 PUSHI: write_reg, alu_src, ctl=PASSB.
  - 0x02 POP: read_reg1.
  - 0x03..0x0A (ADD, SUB, AND, OR, XOR, SHL, SHR, SLT): read_reg1, read_reg2, write_reg, ctl=0..7 respectively.
  - 0x0B ADDI: read_reg1, write_reg, alu_src, ctl=ADD.
  - 0x0C LOAD: read_reg1, read_mem, mem_to_reg, write_reg.
  - 0x0D STORE: read_reg1, read_reg2, write_mem.
  - 0x0E JMP: read_reg1, reg_to_pc.
  - 0x0F CALL: read_reg1, reg_to_pc, pc_to_reg, write_reg.
  - 0x10 BEQZ: read_reg1, read_reg2, ctl=BEQZ.
  - 0x11 BNEZ: read_reg1, read_reg2, ctl=BNEZ.
  - Undefined opcodes decode exactly as NOP.
- ALU: operand1 = tos; operand2 = imm if alu_src else nos. Fully combinational. ctl codes:
  - 0 ADD, 1 SUB: wrap mod 2^32.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR: logical, shift amount = operand2[4:0].
  - 7 SLT: signed compare, result 1 or 0.
  - 8 PASSB: result = operand2.
  - 9 BEQZ: branch = (operand2 == 0), result 0.
  - A BNEZ: branch = (operand2 != 0), result 0.
  - B..F: result 0, branch 0.
  - branch is 0 for every code other than 9 and A.
- Data RAM (2^MEM_AW x DBITS):
  - Address = tos[MEM_AW-1:0]; upper bits ignored (wrap-around).
  - Read is combinational: mem_rdata = RAM[addr] when read_mem, else 0.
  - Write happens on rising clk when write_mem and not reset; data = nos.
  - A LOAD to an address written in the same cycle returns the old data.
  - reset asserted asynchronously clears every word to 0. While reset is high, writes are suppressed and reads return 0. Reset mid-operation discards any pending write.
- reg_wdata: pc+2 if pc_to_reg; else mem_rdata if mem_to_reg; else alu_result.
- next_pc: tos if (reg_to_pc or branch); else pc+1. Wraps mod 2^32.
- No other state. All non-RAM outputs are combinational; they carry no reset value and follow their inputs during reset.

Test Plan:
- Reset: hold reset during clk edges with a STORE pending -> after release, LOAD of any address returns 0.
- Arithmetic and next_pc:
  - ADD: tos=7, nos=5 -> alu_result=12, write_reg=1, read_reg1=read_reg2=1, next_pc=pc+1.
  - SUB: tos=0, nos=1 -> 0xFFFFFFFF.
  - SLT: tos=0xFFFFFFFF, nos=1 -> 1.
- Immediate sign extension:
  - PUSHI with inst[25]=1, inst[24:16]=0x1FF -> reg_wdata=0xFFFFFFFF.
  - ADDI with imm 3, tos=10 -> 13.
- Memory:
  - STORE tos=0x10, nos=0xDEADBEEF, then LOAD tos=0x10 -> mem_rdata=reg_wdata=0xDEADBEEF.
  - LOAD tos=0x110 with MEM_AW=8 -> same word (wrap).
- Branches:
  - BEQZ with nos=0, tos=0x40 -> branch=1, next_pc=0x40.
  - BEQZ with nos=3 -> branch=0, next_pc=pc+1.
  - BNEZ gives the inverse result in both cases.
- Jumps and undefined opcodes:
  - CALL at pc=0x20, tos=0x80 -> reg_wdata=0x22, write_reg=1, next_pc=0x80.
  - JMP -> next_pc=tos.
  - Opcode 0x3F -> all controls 0, branch 0, next_pc=pc+1.
